// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: WIDTH-bit word in over valid/ready, out LSB first on ser_o.
// Define PISO_PARITY_EN to append one even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_q, ser_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             accept;

    assign accept = valid_i && ready_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ser_d   = ser_q;
        busy_d  = busy_q;
        last_d  = last_q;
        ready_d = ready_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // Bit 0 goes straight to the output flop; shift_q holds the bits still to send.
            state_d = ST_SHIFT;
            shift_d = data_i >> 1;
            cnt_d   = '0;
            ser_d   = data_i[0];
            busy_d  = 1'b1;
            last_d  = 1'b0;
            ready_d = 1'b0;
`ifdef PISO_PARITY_EN
            par_d   = data_i[0];
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ser_d   = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                end
                ST_SHIFT: begin
                    if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
                        state_d = ST_PARITY;
                        cnt_d   = cnt_q + CW'(1);
                        ser_d   = par_q;
                        busy_d  = 1'b1;
                        last_d  = 1'b1;
                        ready_d = 1'b1;
`else
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        ser_d   = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                        ser_d   = shift_q[0];
                        busy_d  = 1'b1;
`ifdef PISO_PARITY_EN
                        par_d   = par_q ^ shift_q[0];
                        last_d  = 1'b0;
                        ready_d = 1'b0;
`else
                        last_d  = ((cnt_q + CW'(1)) == LAST_IDX);
                        ready_d = ((cnt_q + CW'(1)) == LAST_IDX);
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PARITY: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ser_d   = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ser_d   = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            ready_q <= ready_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready_o = ready_q;
    assign ser_o   = ser_q;
    assign busy_o  = busy_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed-vector bench for piso_serializer; frame length follows PISO_PARITY_EN.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         ready_o;
    logic         ser_o;
    logic         busy_o;
    logic         last_o;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .ser_o   (ser_o),
        .busy_o  (busy_o),
        .last_o  (last_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents d with valid_i high until it is taken; returns after the accepting edge.
    task automatic accept_word(input logic [W-1:0] d, input string name);
        bit ok;
        ok = 1'b0;
        data_i  = d;
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ready_o === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s accept: ready_o never high within 20 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; data_i = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                rst = 1'b0;
                valid_i = 1'b0;
            end
            tick();
            checks++;
            if ({ready_o, busy_o, last_o, ser_o} !== 4'b1000) begin
                errors++;
                $display("FAIL reset cycle %0d: ready/busy/last/ser=%b required 1000", c,
                         {ready_o, busy_o, last_o, ser_o});
            end
        end
    endtask

    task automatic test_frame(input logic [W-1:0] d, input logic exp_par, input string name);
        logic exp_bit;
        accept_word(d, name);
        valid_i = 1'b0;
        for (int k = 0; k < FL; k++) begin
            exp_bit = (k < W) ? d[k] : exp_par;
            checks++;
            if (ser_o !== exp_bit) begin
                errors++;
                $display("FAIL %s ser bit %0d: got %b required %b", name, k, ser_o, exp_bit);
            end
            checks++;
            if (last_o !== (k == FL - 1)) begin
                errors++;
                $display("FAIL %s last bit %0d: got %b required %b", name, k, last_o, (k == FL - 1));
            end
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s busy bit %0d: got %b required 1", name, k, busy_o);
            end
            if (k < FL - 1) tick();
        end
        tick();
        checks++;
        if ({busy_o, ready_o, ser_o, last_o} !== 4'b0100) begin
            errors++;
            $display("FAIL %s end: busy/ready/ser/last=%b required 0100", name,
                     {busy_o, ready_o, ser_o, last_o});
        end
    endtask

    task automatic test_back_to_back();
        logic [2*FL-1:0] exp_bits;
        logic            exp_last;
`ifdef PISO_PARITY_EN
        exp_bits = {1'b1, 8'h80, 1'b1, 8'h01};
`else
        exp_bits = {8'h80, 8'h01};
`endif
        accept_word(8'h01, "b2b");
        data_i = 8'h80;
        for (int j = 0; j < 2 * FL; j++) begin
            if (j == FL) valid_i = 1'b0;
            exp_last = (j == FL - 1) || (j == 2 * FL - 1);
            checks++;
            if (ser_o !== exp_bits[j]) begin
                errors++;
                $display("FAIL b2b ser bit %0d: got %b required %b", j, ser_o, exp_bits[j]);
            end
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b busy bit %0d: got %b required 1", j, busy_o);
            end
            checks++;
            if ({last_o, ready_o} !== {exp_last, exp_last}) begin
                errors++;
                $display("FAIL b2b last/ready bit %0d: got %b required %b", j,
                         {last_o, ready_o}, {exp_last, exp_last});
            end
            if (j < 2 * FL - 1) tick();
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b end busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_ignored_valid();
        accept_word(8'h00, "ignored");
        valid_i = 1'b0;
        for (int k = 0; k < FL; k++) begin
            checks++;
            if (ser_o !== 1'b0) begin
                errors++;
                $display("FAIL ignored ser bit %0d: got %b required 0", k, ser_o);
            end
            if (k == 2) begin
                data_i  = 8'hFF;
                valid_i = 1'b1;
            end
            if (k == 3) valid_i = 1'b0;
            if (k < FL - 1) tick();
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({busy_o, ser_o} !== 2'b00) begin
                errors++;
                $display("FAIL ignored after %0d: busy/ser=%b required 00", c, {busy_o, ser_o});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        accept_word(8'hFF, "rstmid");
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ser_o !== 1'b1) begin
                errors++;
                $display("FAIL rstmid ser bit %0d: got %b required 1", k, ser_o);
            end
            if (k < 3) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ready_o, busy_o, last_o, ser_o} !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid after reset: ready/busy/last/ser=%b required 1000",
                     {ready_o, busy_o, last_o, ser_o});
        end
        for (int c = 0; c < FL; c++) begin
            tick();
            checks++;
            if ({busy_o, last_o, ser_o} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid tail %0d: busy/last/ser=%b required 000", c,
                         {busy_o, last_o, ser_o});
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        test_reset();
        test_frame(8'hA5, 1'b0, "frame_a5");
        test_frame(8'h07, 1'b1, "frame_07");
        test_back_to_back();
        test_ignored_valid();
        test_reset_mid_frame();
        test_frame(8'h5A, 1'b0, "frame_5a");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
